// File: rtl/ctrl_pipe_unit.sv
// EX-stage control decoder with M-extension stall FSM and WB control registers.
// Latency: EX outputs are combinational; WB outputs are registered, one cycle after retirement.
// Backpressure: stall holds IF/EX while a multi-cycle M-op is in EX; stalled cycles send bubbles to WB.
module ctrl_pipe_unit #(
  parameter int          N_GPIO       = 1,
  parameter logic [11:0] CSR_OUT_BASE = 12'hF00,
  parameter logic [11:0] CSR_IN_BASE  = 12'hF02,
  parameter int          CSR_STRIDE   = 4,
  parameter int          MULDIV_LAT   = 1
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic [31:0]               instr_EX,
  input  logic                      instr_valid,
  input  logic                      flush,
  output logic [1:0]                alusrc_EX,
  output logic [3:0]                aluop_EX,
  output logic                      div_unsigned_EX,
  output logic                      regwrite_EX,
  output logic [1:0]                regsel_EX,
  output logic [$clog2(N_GPIO):0]   gpio_rd_sel,
  output logic [N_GPIO-1:0]         gpio_we_EX,
  output logic                      illegal_EX,
  output logic                      stall,
  output logic                      regwrite_WB,
  output logic [1:0]                regsel_WB,
  output logic [N_GPIO-1:0]         gpio_we_WB
);

  localparam int SW = $clog2(N_GPIO) + 1;
  localparam int CW = $clog2(MULDIV_LAT) + 1;
  localparam bit MULTI_CYCLE = (MULDIV_LAT > 1);
  // The IDLE cycle is the first stall cycle, so BUSY counts down the remaining LAT-2.
  localparam logic [CW-1:0] CNT_LOAD = MULTI_CYCLE ? CW'(MULDIV_LAT - 2) : '0;

  localparam logic [6:0] OPC_R   = 7'b0110011;
  localparam logic [6:0] OPC_I   = 7'b0010011;
  localparam logic [6:0] OPC_LUI = 7'b0110111;
  localparam logic [6:0] OPC_SYS = 7'b1110011;

  localparam logic [3:0] OP_AND  = 4'b0000, OP_XOR = 4'b0001, OP_OR   = 4'b0010, OP_ADD   = 4'b0011;
  localparam logic [3:0] OP_SUB  = 4'b0100, OP_SLL = 4'b0101, OP_SRL  = 4'b0110, OP_SRA   = 4'b0111;
  localparam logic [3:0] OP_SLT  = 4'b1000, OP_SLTU = 4'b1001, OP_MUL = 4'b1010, OP_MULH  = 4'b1011;
  localparam logic [3:0] OP_MULHSU = 4'b1100, OP_MULHU = 4'b1101, OP_DIV = 4'b1110, OP_REM = 4'b1111;

  typedef enum logic {S_IDLE = 1'b0, S_BUSY = 1'b1} state_t;

  state_t          r_state, w_state_nxt;
  logic [CW-1:0]   r_cnt, w_cnt_nxt;

  logic [6:0]      w_op;
  logic [2:0]      w_f3;
  logic [6:0]      w_f7;
  logic [11:0]     w_imm12;
  logic [1:0]      w_alusrc;
  logic [3:0]      w_aluop;
  logic            w_divu;
  logic            w_rw;
  logic [1:0]      w_regsel;
  logic [SW-1:0]   w_rdsel;
  logic [N_GPIO-1:0] w_gwe;
  logic            w_ill;
  logic            w_mop;
  logic            w_bad;
  logic            w_hit;
  logic            w_kill;
  logic            w_live;
  logic            w_mop_start;
  logic            w_unused;

  assign w_op     = instr_EX[6:0];
  assign w_f3     = instr_EX[14:12];
  assign w_f7     = instr_EX[31:25];
  assign w_imm12  = instr_EX[31:20];
  assign w_unused = ^{instr_EX[19:15], instr_EX[11:7]};

  // Instruction decode: raw EX control before valid/flush/stall masking.
  always_comb begin
    w_alusrc = 2'b00;
    w_aluop  = OP_AND;
    w_divu   = 1'b0;
    w_rw     = 1'b0;
    w_regsel = 2'b00;
    w_rdsel  = '0;
    w_gwe    = '0;
    w_ill    = 1'b0;
    w_mop    = 1'b0;
    w_bad    = 1'b0;
    w_hit    = 1'b0;
    case (w_op)
      OPC_R: begin
        case (w_f7)
          7'b0000000: begin
            case (w_f3)
              3'b000:  w_aluop = OP_ADD;
              3'b001:  w_aluop = OP_SLL;
              3'b010:  w_aluop = OP_SLT;
              3'b011:  w_aluop = OP_SLTU;
              3'b100:  w_aluop = OP_XOR;
              3'b101:  w_aluop = OP_SRL;
              3'b110:  w_aluop = OP_OR;
              default: w_aluop = OP_AND;
            endcase
          end
          7'b0100000: begin
            if (w_f3 == 3'b000)      w_aluop = OP_SUB;
            else if (w_f3 == 3'b101) w_aluop = OP_SRA;
            else                     w_bad   = 1'b1;
          end
          7'b0000001: begin
            w_mop = 1'b1;
            case (w_f3)
              3'b000:  w_aluop = OP_MUL;
              3'b001:  w_aluop = OP_MULH;
              3'b010:  w_aluop = OP_MULHSU;
              3'b011:  w_aluop = OP_MULHU;
              3'b100:  w_aluop = OP_DIV;
              3'b101: begin w_aluop = OP_DIV; w_divu = 1'b1; end
              3'b110:  w_aluop = OP_REM;
              default: begin w_aluop = OP_REM; w_divu = 1'b1; end
            endcase
          end
          default: w_bad = 1'b1;
        endcase
        if (w_bad) begin
          // Unsupported R-type encodings carry no side effects into the pipe.
          w_aluop = OP_AND;
          w_mop   = 1'b0;
          w_ill   = 1'b1;
        end else begin
          w_rw     = 1'b1;
          w_regsel = 2'b10;
        end
      end
      OPC_I: begin
        w_rw     = 1'b1;
        w_alusrc = 2'b01;
        w_regsel = 2'b10;
        case (w_f3)
          3'b000:  w_aluop = OP_ADD;
          3'b001:  w_aluop = OP_SLL;
          3'b010:  w_aluop = OP_SLT;
          3'b011:  w_aluop = OP_SLTU;
          3'b100:  w_aluop = OP_XOR;
          3'b101:  w_aluop = instr_EX[30] ? OP_SRA : OP_SRL;
          3'b110:  w_aluop = OP_OR;
          default: w_aluop = OP_AND;
        endcase
      end
      OPC_LUI: begin
        w_rw     = 1'b1;
        w_alusrc = 2'b10;
        w_regsel = 2'b01;
      end
      OPC_SYS: begin
        if (w_f3 == 3'b001) begin
          // Output channels take priority; first matching channel wins so at most one strobe fires.
          for (int k = 0; k < N_GPIO; k++) begin
            if (!w_hit && (w_imm12 == 12'(int'(CSR_OUT_BASE) + k * CSR_STRIDE))) begin
              w_gwe[k] = 1'b1;
              w_hit    = 1'b1;
            end
          end
          for (int k = 0; k < N_GPIO; k++) begin
            if (!w_hit && (w_imm12 == 12'(int'(CSR_IN_BASE) + k * CSR_STRIDE))) begin
              w_rw     = 1'b1;
              w_regsel = 2'b11;
              w_rdsel  = SW'(k);
              w_hit    = 1'b1;
            end
          end
          w_ill = !w_hit;
        end else begin
          w_ill = 1'b1;
        end
      end
      default: w_ill = 1'b1;
    endcase
  end

  assign w_kill      = !instr_valid || flush;
  assign w_live      = !w_kill && !stall;
  assign w_mop_start = MULTI_CYCLE && instr_valid && w_mop && !flush;

  assign alusrc_EX       = w_alusrc;
  assign aluop_EX        = w_aluop;
  assign div_unsigned_EX = w_divu;
  assign regsel_EX       = w_regsel;
  assign gpio_rd_sel     = w_rdsel;
  assign regwrite_EX     = w_rw && w_live;
  assign gpio_we_EX      = w_gwe & {N_GPIO{w_live}};
  assign illegal_EX      = w_ill && !w_kill;

  // FSM state register: M-op occupancy and remaining stall count.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= S_IDLE;
      r_cnt   <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_cnt   <= w_cnt_nxt;
    end
  end

  // FSM next state: enter BUSY on a multi-cycle M-op, leave on count expiry or flush.
  always_comb begin
    w_state_nxt = r_state;
    w_cnt_nxt   = r_cnt;
    case (r_state)
      S_IDLE: begin
        if (w_mop_start) begin
          w_state_nxt = S_BUSY;
          w_cnt_nxt   = CNT_LOAD;
        end
      end
      default: begin
        if (flush || (r_cnt == '0)) begin
          w_state_nxt = S_IDLE;
          w_cnt_nxt   = '0;
        end else begin
          w_cnt_nxt = r_cnt - 1'b1;
        end
      end
    endcase
  end

  // FSM output: stall; gated by rst_n so an asserted reset drops it even if an M-op is still presented.
  always_comb begin
    stall = 1'b0;
    case (r_state)
      S_IDLE:  stall = w_mop_start;
      default: stall = (r_cnt != '0) && !flush;
    endcase
    stall = stall && rst_n;
  end

  // WB control registers: load masked EX control every edge, so killed or stalled cycles become bubbles.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      regwrite_WB <= 1'b0;
      regsel_WB   <= 2'b00;
      gpio_we_WB  <= '0;
    end else begin
      regwrite_WB <= regwrite_EX;
      regsel_WB   <= w_live ? w_regsel : 2'b00;
      gpio_we_WB  <= gpio_we_EX;
    end
  end

endmodule

// File: tb/tb_ctrl_pipe_unit.sv
// Directed-vector bench for ctrl_pipe_unit (N_GPIO=2, MULDIV_LAT=4).
// Driver pushes expected output bundle per cycle; monitor pops and compares at the falling edge.
module tb_ctrl_pipe_unit;

  logic        clk;
  logic        rst_n;
  logic [31:0] instr_EX;
  logic        instr_valid;
  logic        flush;
  logic [1:0]  alusrc_EX;
  logic [3:0]  aluop_EX;
  logic        div_unsigned_EX;
  logic        regwrite_EX;
  logic [1:0]  regsel_EX;
  logic [1:0]  gpio_rd_sel;
  logic [1:0]  gpio_we_EX;
  logic        illegal_EX;
  logic        stall;
  logic        regwrite_WB;
  logic [1:0]  regsel_WB;
  logic [1:0]  gpio_we_WB;

  ctrl_pipe_unit #(
    .N_GPIO(2), .CSR_OUT_BASE(12'hF00), .CSR_IN_BASE(12'hF02), .CSR_STRIDE(4), .MULDIV_LAT(4)
  ) dut (
    .clk(clk), .rst_n(rst_n), .instr_EX(instr_EX), .instr_valid(instr_valid), .flush(flush),
    .alusrc_EX(alusrc_EX), .aluop_EX(aluop_EX), .div_unsigned_EX(div_unsigned_EX),
    .regwrite_EX(regwrite_EX), .regsel_EX(regsel_EX), .gpio_rd_sel(gpio_rd_sel),
    .gpio_we_EX(gpio_we_EX), .illegal_EX(illegal_EX), .stall(stall),
    .regwrite_WB(regwrite_WB), .regsel_WB(regsel_WB), .gpio_we_WB(gpio_we_WB)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  logic [20:0] exp_q[$];
  logic [20:0] msk_q[$];
  string       nm_q[$];
  int          n_vec = 0;
  int          n_bad = 0;

  // Bundle layout: alusrc, aluop, divu, regwrite_EX, regsel_EX, rd_sel, gpio_we_EX, illegal, stall, regwrite_WB, regsel_WB, gpio_we_WB
  function automatic logic [20:0] pk(input int as, input int op, input int du, input int rw,
                                     input int rs, input int sel, input int gw, input int il,
                                     input int st, input int rww, input int rsw, input int gww);
    return {as[1:0], op[3:0], du[0], rw[0], rs[1:0], sel[1:0], gw[1:0], il[0], st[0],
            rww[0], rsw[1:0], gww[1:0]};
  endfunction

  task automatic apply(input logic rn, input logic [31:0] ins, input logic v, input logic f,
                       input logic [20:0] e, input logic [20:0] m, input string nm);
    @(posedge clk);
    #1;
    rst_n       = rn;
    instr_EX    = ins;
    instr_valid = v;
    flush       = f;
    exp_q.push_back(e);
    msk_q.push_back(m);
    nm_q.push_back(nm);
  endtask

  // Monitor: one expected bundle per driven cycle, checked mid-cycle.
  initial begin
    logic [20:0] act, e, m;
    string nm;
    forever begin
      @(negedge clk);
      if (exp_q.size() > 0) begin
        e  = exp_q.pop_front();
        m  = msk_q.pop_front();
        nm = nm_q.pop_front();
        act = {alusrc_EX, aluop_EX, div_unsigned_EX, regwrite_EX, regsel_EX, gpio_rd_sel,
               gpio_we_EX, illegal_EX, stall, regwrite_WB, regsel_WB, gpio_we_WB};
        n_vec++;
        if ((act & m) !== (e & m)) begin
          n_bad++;
          $display("FAIL %s: got %h expected %h (mask %h)", nm, act & m, e & m, m);
        end
      end
    end
  end

  localparam logic [31:0] ADD   = 32'h002081B3;
  localparam logic [31:0] DIV   = 32'h0220C1B3;
  localparam logic [31:0] DIVU  = 32'h0220D1B3;
  localparam logic [31:0] MULHU = 32'h0220B1B3;

  initial begin
    logic [20:0] m_all, m_nsw, m_ill, m_wb;
    m_all = pk(3, 15, 1, 1, 3, 3, 3, 1, 1, 1, 3, 3);
    m_nsw = pk(3, 15, 1, 1, 3, 3, 3, 1, 1, 1, 0, 3);
    m_ill = pk(0, 0, 0, 1, 0, 0, 3, 1, 1, 1, 3, 3);
    m_wb  = pk(0, 0, 0, 0, 0, 0, 0, 0, 1, 1, 3, 3);
    rst_n = 1'b0; instr_EX = '0; instr_valid = 1'b0; flush = 1'b0;

    apply(0, 32'h0, 0, 0, pk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0), m_all, "reset");
    apply(1, 32'h0, 0, 0, pk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0), m_all, "post_rst_idle");
    apply(1, ADD, 1, 0, pk(0, 3, 0, 1, 2, 0, 0, 0, 0, 0, 0, 0), m_all, "add");
    apply(1, 32'h4050D213, 1, 0, pk(1, 7, 0, 1, 2, 0, 0, 0, 0, 1, 2, 0), m_all, "srai");
    apply(1, 32'h0010B213, 1, 0, pk(1, 9, 0, 1, 2, 0, 0, 0, 0, 1, 2, 0), m_all, "sltiu");
    apply(1, ADD, 0, 0, pk(0, 3, 0, 0, 2, 0, 0, 0, 0, 1, 2, 0), m_all, "invalid_add");
    apply(1, 32'h40208233, 1, 0, pk(0, 4, 0, 1, 2, 0, 0, 0, 0, 0, 0, 0), m_nsw, "sub");
    apply(1, 32'h4000F033, 1, 0, pk(0, 0, 0, 0, 0, 0, 0, 1, 0, 1, 2, 0), m_ill, "illegal_r");
    apply(1, ADD, 1, 1, pk(0, 3, 0, 0, 2, 0, 0, 0, 0, 0, 0, 0), m_nsw, "flush_add");
    apply(1, 32'hF0029073, 1, 0, pk(0, 0, 0, 0, 0, 0, 1, 0, 0, 0, 0, 0), m_nsw, "gpio_wr0");
    apply(1, 32'hF0429073, 1, 0, pk(0, 0, 0, 0, 0, 0, 2, 0, 0, 0, 0, 1), m_all, "gpio_wr1");
    apply(1, 32'hF06013F3, 1, 0, pk(0, 0, 0, 1, 3, 1, 0, 0, 0, 0, 0, 2), m_all, "gpio_rd1");
    apply(1, 32'hF02013F3, 1, 0, pk(0, 0, 0, 1, 3, 0, 0, 0, 0, 1, 3, 0), m_all, "gpio_rd0");
    apply(1, 32'hF0A29073, 1, 0, pk(0, 0, 0, 0, 0, 0, 0, 1, 0, 1, 3, 0), m_all, "csr_nomatch");
    apply(1, 32'h123452B7, 1, 0, pk(2, 0, 0, 1, 1, 0, 0, 0, 0, 0, 0, 0), m_all, "lui");
    // DIV held: three stall cycles then retirement, WB one cycle later
    apply(1, DIV, 1, 0, pk(0, 14, 0, 0, 2, 0, 0, 0, 1, 1, 1, 0), m_all, "div_s1");
    apply(1, DIV, 1, 0, pk(0, 14, 0, 0, 2, 0, 0, 0, 1, 0, 0, 0), m_all, "div_s2");
    apply(1, DIV, 1, 0, pk(0, 14, 0, 0, 2, 0, 0, 0, 1, 0, 0, 0), m_all, "div_s3");
    apply(1, DIV, 1, 0, pk(0, 14, 0, 1, 2, 0, 0, 0, 0, 0, 0, 0), m_all, "div_retire");
    // DIVU flushed in its second stall cycle
    apply(1, DIVU, 1, 0, pk(0, 14, 1, 0, 2, 0, 0, 0, 1, 1, 2, 0), m_all, "divu_s1");
    apply(1, DIVU, 1, 0, pk(0, 14, 1, 0, 2, 0, 0, 0, 1, 0, 0, 0), m_all, "divu_s2");
    apply(1, DIVU, 1, 1, pk(0, 14, 1, 0, 2, 0, 0, 0, 0, 0, 0, 0), m_all, "divu_flush");
    apply(1, ADD, 1, 0, pk(0, 3, 0, 1, 2, 0, 0, 0, 0, 0, 0, 0), m_all, "add_after_flush");
    apply(1, 32'h0, 0, 0, pk(0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 2, 0), m_all, "bubble");
    // Reset asserted while BUSY
    apply(1, DIV, 1, 0, pk(0, 14, 0, 0, 2, 0, 0, 0, 1, 0, 0, 0), m_all, "div2_s1");
    apply(1, DIV, 1, 0, pk(0, 14, 0, 0, 2, 0, 0, 0, 1, 0, 0, 0), m_all, "div2_s2");
    apply(0, DIV, 1, 0, pk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0), m_wb, "rst_busy");
    apply(1, ADD, 1, 0, pk(0, 3, 0, 1, 2, 0, 0, 0, 0, 0, 0, 0), m_all, "add_after_rst");
    apply(1, 32'h0, 0, 0, pk(0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 2, 0), m_all, "add_wb");
    // Asynchronous clear of a loaded WB register
    apply(1, ADD, 1, 0, pk(0, 3, 0, 1, 2, 0, 0, 0, 0, 0, 0, 0), m_all, "add3");
    apply(0, ADD, 1, 0, pk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0), m_wb, "async_wb_clear");
    apply(1, 32'h0, 0, 0, pk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0), m_all, "rst_release");
    // MULHU full occupancy
    apply(1, MULHU, 1, 0, pk(0, 13, 0, 0, 2, 0, 0, 0, 1, 0, 0, 0), m_all, "mulhu_s1");
    apply(1, MULHU, 1, 0, pk(0, 13, 0, 0, 2, 0, 0, 0, 1, 0, 0, 0), m_all, "mulhu_s2");
    apply(1, MULHU, 1, 0, pk(0, 13, 0, 0, 2, 0, 0, 0, 1, 0, 0, 0), m_all, "mulhu_s3");
    apply(1, MULHU, 1, 0, pk(0, 13, 0, 1, 2, 0, 0, 0, 0, 0, 0, 0), m_all, "mulhu_retire");
    apply(1, 32'h0, 0, 0, pk(0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 2, 0), m_all, "mulhu_wb");

    repeat (4) @(posedge clk);
    if (exp_q.size() != 0) begin
      n_bad++;
      $display("FAIL drain: got %0d pending expected 0", exp_q.size());
    end
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
